// File: rtl/router_tx.sv
// Burst transmitter: stages producer words in a small FIFO and drives them into a router source port.
// Latency: a word accepted into an empty FIFO is presented on the second cycle after acceptance; src_ready_o drops when FIFO full or burst quota met.

// Staging FIFO: registered full/empty from an occupancy counter; read data is combinational from the head.
module router_tx_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_i && !pop_i)      count_q <= count_q + 1'b1;
            else if (pop_i && !push_i) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign pop_dat_o = mem_q[rd_ptr_q];
    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
endmodule

module router_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_valid_i,
    input  logic [3:0]            cfg_mode_i,
    input  logic [LEN_WIDTH-1:0]  cfg_len_i,
    output logic                  cfg_ready_o,
    input  logic [DATA_WIDTH-1:0] src_data_i,
    input  logic                  src_valid_i,
    output logic                  src_ready_o,
    output logic [DATA_WIDTH-1:0] router_data_o,
    output logic                  router_enable_o,
    output logic [3:0]            router_mode_o,
    output logic                  busy_o,
    output logic                  done_o
);
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t                state_q, state_d;
    logic [3:0]            mode_q, mode_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  acc_q, acc_d;
    logic [LEN_WIDTH-1:0]  sent_q, sent_d;
    logic [DATA_WIDTH-1:0] out_dat_q;
    logic                  out_vld_q;

    logic                  fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_dat;
    logic                  cfg_hs, src_hs, pop, last_pop;

    assign cfg_hs   = cfg_valid_i && (state_q == IDLE);
    assign src_hs   = src_valid_i && src_ready_o;
    assign pop      = (state_q == SEND) && !fifo_empty;
    assign last_pop = ((sent_q + 1'b1) == len_q);

    router_tx_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (src_hs),
        .push_dat_i (src_data_i),
        .pop_i      (pop),
        .pop_dat_o  (fifo_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_hs) state_d = (cfg_len_i != '0) ? SEND : DONE;
            SEND:    if (pop && last_pop) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake readiness follows the reset state while reset is held.
    always_comb begin
        cfg_ready_o = reset || (state_q == IDLE);
        src_ready_o = !reset && (state_q == SEND) && !fifo_full && (acc_q < len_q);
        busy_o      = (state_q != IDLE);
        done_o      = (state_q == DONE);
    end

    always_comb begin
        mode_d = mode_q;
        len_d  = len_q;
        acc_d  = acc_q;
        sent_d = sent_q;
        if (cfg_hs) begin
            mode_d = cfg_mode_i;
            len_d  = cfg_len_i;
            acc_d  = '0;
            sent_d = '0;
        end else begin
            if (src_hs) acc_d  = acc_q + 1'b1;
            if (pop)    sent_d = sent_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q    <= '0;
            len_q     <= '0;
            acc_q     <= '0;
            sent_q    <= '0;
            out_dat_q <= '0;
            out_vld_q <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            len_q     <= len_d;
            acc_q     <= acc_d;
            sent_q    <= sent_d;
            out_vld_q <= pop;
            if (pop) out_dat_q <= fifo_dat;
        end
    end

    assign router_data_o   = out_dat_q;
    assign router_enable_o = out_vld_q;
    assign router_mode_o   = mode_q;
endmodule

// File: tb/tb_router_tx.sv
// Directed bench for router_tx: expected words are queued at source handshake and checked as they leave.
module tb_router_tx;
    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_valid_i;
    logic [3:0]  cfg_mode_i;
    logic [7:0]  cfg_len_i;
    logic        cfg_ready_o;
    logic [15:0] src_data_i;
    logic        src_valid_i;
    logic        src_ready_o;
    logic [15:0] router_data_o;
    logic        router_enable_o;
    logic [3:0]  router_mode_o;
    logic        busy_o;
    logic        done_o;

    typedef struct packed {
        logic [15:0] dat;
        logic [3:0]  mode;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;
    int   out_cnt = 0;
    int   done_cnt = 0;
    int   base;
    int   n;

    router_tx dut (
        .clk             (clk),
        .reset           (reset),
        .cfg_valid_i     (cfg_valid_i),
        .cfg_mode_i      (cfg_mode_i),
        .cfg_len_i       (cfg_len_i),
        .cfg_ready_o     (cfg_ready_o),
        .src_data_i      (src_data_i),
        .src_valid_i     (src_valid_i),
        .src_ready_o     (src_ready_o),
        .router_data_o   (router_data_o),
        .router_enable_o (router_enable_o),
        .router_mode_o   (router_mode_o),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [3:0] m, input logic [7:0] l);
        int k;
        cfg_mode_i  = m;
        cfg_len_i   = l;
        cfg_valid_i = 1'b1;
        k = 0;
        while (!cfg_ready_o && k < 50) begin
            step();
            k++;
        end
        chk("cfg_ready_wait", 32'(cfg_ready_o), 32'd1);
        step();
        cfg_valid_i = 1'b0;
    endtask

    task automatic word(input logic [15:0] d, input logic [3:0] m, input logic last);
        int k;
        src_data_i  = d;
        src_valid_i = 1'b1;
        k = 0;
        while (!src_ready_o && k < 50) begin
            step();
            k++;
        end
        chk("src_ready_wait", 32'(src_ready_o), 32'd1);
        exp_q.push_back('{dat: d, mode: m, last: last});
        step();
        src_valid_i = 1'b0;
    endtask

    // Output monitor: every strobe must match the oldest accepted word.
    always @(negedge clk) begin
        if (!reset) begin
            if (router_enable_o) begin
                out_cnt++;
                chk("word_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("router_data", 32'(router_data_o), 32'(e.dat));
                    chk("router_mode", 32'(router_mode_o), 32'(e.mode));
                    chk("done_with_last", 32'(done_o), 32'(e.last));
                end
            end
            if (done_o) done_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; cfg_valid_i = 1'b0; cfg_mode_i = '0; cfg_len_i = '0;
        src_data_i = '0; src_valid_i = 1'b0;
        step();
        step();
        chk("rst_enable", 32'(router_enable_o), 32'd0);
        chk("rst_data", 32'(router_data_o), 32'd0);
        chk("rst_mode", 32'(router_mode_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready_o), 32'd1);
        chk("rst_src_ready", 32'(src_ready_o), 32'd0);
        reset = 1'b0;
        step();

        // Basic burst of three consecutive words
        cmd(4'd1, 8'd3);
        chk("busy_send", 32'(busy_o), 32'd1);
        chk("cfg_ready_send", 32'(cfg_ready_o), 32'd0);
        word(16'h0A01, 4'd1, 1'b0);
        word(16'h0A02, 4'd1, 1'b0);
        word(16'h0A03, 4'd1, 1'b1);
        repeat (4) step();
        chk("b1_idle_busy", 32'(busy_o), 32'd0);
        chk("b1_idle_mode_hold", 32'(router_mode_o), 32'd1);
        chk("b1_drained", 32'(exp_q.size()), 32'd0);

        // Zero-length burst
        cmd(4'd3, 8'd0);
        chk("len0_done", 32'(done_o), 32'd1);
        chk("len0_src_ready", 32'(src_ready_o), 32'd0);
        chk("len0_busy", 32'(busy_o), 32'd1);
        step();
        chk("len0_done_end", 32'(done_o), 32'd0);
        chk("len0_cfg_ready", 32'(cfg_ready_o), 32'd1);
        chk("len0_busy_end", 32'(busy_o), 32'd0);

        // Eight words with source valid held constantly
        cmd(4'd7, 8'd8);
        for (int i = 0; i < 8; i++) word(16'(16'h7000 + i), 4'd7, i == 7);
        src_valid_i = 1'b1;
        src_data_i  = 16'hDEAD;
        chk("len8_ready_drop", 32'(src_ready_o), 32'd0);
        step();
        chk("len8_ready_drop2", 32'(src_ready_o), 32'd0);
        src_valid_i = 1'b0;
        repeat (4) step();
        chk("len8_drained", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a five-word burst
        base = out_cnt;
        cmd(4'd5, 8'd5);
        word(16'h5001, 4'd5, 1'b0);
        word(16'h5002, 4'd5, 1'b0);
        word(16'h5003, 4'd5, 1'b0);
        n = 0;
        while (out_cnt < base + 2 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("mid_two_sent", 32'(out_cnt - base), 32'd2);
        reset = 1'b1;
        #1;
        chk("inrst_cfg_ready", 32'(cfg_ready_o), 32'd1);
        chk("inrst_src_ready", 32'(src_ready_o), 32'd0);
        @(posedge clk);
        #1;
        exp_q.delete();
        chk("mid_rst_enable", 32'(router_enable_o), 32'd0);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_mode", 32'(router_mode_o), 32'd0);
        step();
        reset = 1'b0;
        repeat (3) step();
        chk("mid_no_more", 32'(out_cnt - base), 32'd2);
        cmd(4'd2, 8'd1);
        word(16'h1234, 4'd2, 1'b1);
        repeat (3) step();
        chk("post_rst_mode", 32'(router_mode_o), 32'd2);
        chk("post_rst_drained", 32'(exp_q.size()), 32'd0);

        // Command held valid during a burst
        cmd(4'd0, 8'd3);
        cfg_mode_i = 4'd4; cfg_len_i = 8'd1; cfg_valid_i = 1'b1;
        word(16'h0C01, 4'd0, 1'b0);
        word(16'h0C02, 4'd0, 1'b0);
        word(16'h0C03, 4'd0, 1'b1);
        n = 0;
        while (!done_o && n < 20) begin
            step();
            n++;
        end
        chk("hold_done", 32'(done_o), 32'd1);
        chk("hold_cfg_ready_done", 32'(cfg_ready_o), 32'd0);
        chk("hold_mode_done", 32'(router_mode_o), 32'd0);
        step();
        chk("hold_idle_ready", 32'(cfg_ready_o), 32'd1);
        chk("hold_idle_busy", 32'(busy_o), 32'd0);
        step();
        cfg_valid_i = 1'b0;
        chk("hold_second_busy", 32'(busy_o), 32'd1);
        chk("hold_second_mode", 32'(router_mode_o), 32'd4);
        word(16'h4444, 4'd4, 1'b1);
        repeat (4) step();
        chk("hold_drained", 32'(exp_q.size()), 32'd0);

        chk("total_words", 32'(out_cnt), 32'd18);
        chk("total_done", 32'(done_cnt), 32'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
